// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with bypass, pending scoreboard and init sweep
module regfile_mp #(
    parameter int DWIDTH = 512,
    parameter int DEPTH  = 16,
    parameter int NRD    = 2,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_req,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [AWIDTH-1:0]        wr_addr,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic [DWIDTH/8-1:0]      wr_be,
    input  logic                     pend_set,
    input  logic [AWIDTH-1:0]        pend_addr,
    input  logic [NRD-1:0]           rd_en,
    input  logic [NRD*AWIDTH-1:0]    rd_addr,
    output logic [NRD*DWIDTH-1:0]    rd_data,
    output logic [NRD-1:0]           rd_valid,
    output logic [NRD-1:0]           rd_pend
);
    localparam int NBYTE = DWIDTH / 8;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [AWIDTH-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic [NRD*DWIDTH-1:0] rd_data_q, rd_data_d;
    logic [NRD-1:0]        rd_valid_q, rd_valid_d;
    logic [NRD-1:0]        rd_pend_q, rd_pend_d;

    logic                  run;
    logic                  wr_ok;
    logic                  ps_ok;
    logic                  mem_we;
    logic [AWIDTH-1:0]     mem_waddr;
    logic [DWIDTH-1:0]     mem_wdata;
    logic [NBYTE-1:0]      mem_wbe;

    // Addresses at or above DEPTH exist only when DEPTH is not a power of two.
    function automatic logic in_range(input logic [AWIDTH-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    assign run   = (state_q == ST_RUN);
    assign busy  = ~run;
    assign wr_ok = run && wr_en && in_range(wr_addr);
    assign ps_ok = run && pend_set && in_range(pend_addr);

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_pend  = rd_pend_q;

    // Init sweep sequencer: one entry per cycle, then hand over to normal operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AWIDTH'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Array write port is shared between the sweep (zero fill) and the user write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else if (wr_ok) begin
            mem_we = 1'b1;
        end
    end

    // Scoreboard: write clears first, so a same-cycle set on the same entry wins.
    always_comb begin
        pend_d = pend_q;
        if (!run) begin
            pend_d[cnt_q] = 1'b0;
        end else begin
            if (wr_ok) pend_d[wr_addr]   = 1'b0;
            if (ps_ok) pend_d[pend_addr] = 1'b1;
        end
    end

    // Read ports: byte-merged bypass of the concurrent write; pend reflects the write-clear only.
    always_comb begin
        logic [AWIDTH-1:0] a;
        logic [DWIDTH-1:0] v;
        logic              hit;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        rd_pend_d  = rd_pend_q;
        a          = '0;
        v          = '0;
        hit        = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            a   = rd_addr[k*AWIDTH +: AWIDTH];
            hit = wr_ok && (wr_addr == a);
            v   = mem_q[a];
            for (int b = 0; b < NBYTE; b++) begin
                if (hit && wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
            end
            if (run && rd_en[k]) begin
                rd_valid_d[k] = 1'b1;
                if (in_range(a)) begin
                    rd_data_d[k*DWIDTH +: DWIDTH] = v;
                    rd_pend_d[k]                  = hit ? 1'b0 : pend_q[a];
                end else begin
                    rd_data_d[k*DWIDTH +: DWIDTH] = '0;
                    rd_pend_d[k]                  = 1'b0;
                end
            end
        end
    end

    // Control, scoreboard and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            pend_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            rd_pend_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // Storage array is never reset; the sweep establishes its contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (mem_wbe[b]) mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp
module tb_regfile_mp;
    localparam int DW  = 64;
    localparam int DEP = 16;
    localparam int NR  = 2;
    localparam int AW  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           init_req = 1'b0;
    logic           busy;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic [DW/8-1:0] wr_be = '0;
    logic           pend_set = 1'b0;
    logic [AW-1:0]  pend_addr = '0;
    logic [NR-1:0]  rd_en = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_valid;
    logic [NR-1:0]  rd_pend;

    int n_pass = 0;
    int n_total = 0;

    regfile_mp #(.DWIDTH(DW), .DEPTH(DEP), .NRD(NR)) dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_pend(rd_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain arrays, an init countdown and expected output registers.
    logic [DW-1:0]    m [DEP];
    bit               p [DEP];
    int               sweep;
    bit               m_init;
    bit               m_live = 1'b0;
    logic [NR*DW-1:0] e_data;
    logic [NR-1:0]    e_valid;
    logic [NR-1:0]    e_pend;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [DW/8-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < DW/8; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_data  = '0;
            e_valid = '0;
            e_pend  = '0;
            for (int i = 0; i < DEP; i++) p[i] = 1'b0;
            sweep   = 0;
            m_init  = 1'b1;
            m_live  = 1'b1;
        end else if (m_init) begin
            m[sweep] = '0;
            p[sweep] = 1'b0;
            e_valid  = '0;
            sweep++;
            if (sweep == DEP) m_init = 1'b0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int a;
                a = int'(rd_addr[k*AW +: AW]);
                e_valid[k] = rd_en[k];
                if (rd_en[k]) begin
                    if (wr_en && int'(wr_addr) == a) begin
                        e_data[k*DW +: DW] = merge(m[a], wr_data, wr_be);
                        e_pend[k] = 1'b0;
                    end else begin
                        e_data[k*DW +: DW] = m[a];
                        e_pend[k] = p[a];
                    end
                end
            end
            if (wr_en) begin
                m[wr_addr] = merge(m[wr_addr], wr_data, wr_be);
                p[wr_addr] = 1'b0;
            end
            if (pend_set) p[pend_addr] = 1'b1;
            if (init_req) begin
                m_init = 1'b1;
                sweep  = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", 128'(busy), 128'(m_init));
            chk("rd_valid", 128'(rd_valid), 128'(e_valid));
            chk("rd_data", 128'(rd_data), 128'(e_data));
            chk("rd_pend", 128'(rd_pend), 128'(e_pend));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        init_req = 1'b0;
        wr_en    = 1'b0;
        pend_set = 1'b0;
        rd_en    = '0;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk(name, 128'(n), 128'(DEP));
    endtask

    initial begin
        logic [DW-1:0] a5;
        a5 = {8{8'hA5}};

        repeat (3) tick();
        rst_n = 1'b1;
        chk("busy_after_reset", 128'(busy), 128'(1));
        count_busy("busy_len_reset");

        // Reads of first and last entry after the sweep.
        rd_en = 2'b11; rd_addr = {4'd15, 4'd0};
        tick(); idle();
        chk("post_init_valid", 128'(rd_valid), 128'(2'b11));
        chk("post_init_data", 128'(rd_data), 128'(0));

        // Full write then byte-0-only write.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = a5; wr_be = '1;
        tick();
        wr_data = '0; wr_be = 8'h01;
        tick(); idle();
        rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
        tick(); idle();
        chk("byte_enable", 128'(rd_data[DW-1:0]), 128'(64'hA5A5A5A5A5A5A500));

        // Write-to-read bypass on both ports.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 64'h1234; wr_be = '1;
        rd_en = 2'b11; rd_addr = {4'd7, 4'd7};
        tick(); idle();
        chk("bypass_valid", 128'(rd_valid), 128'(2'b11));
        chk("bypass_data", 128'(rd_data), {64'h1234, 64'h1234});

        // Scoreboard.
        pend_set = 1'b1; pend_addr = 4'd5;
        tick(); idle();
        rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
        tick(); idle();
        chk("pend_set", 128'(rd_pend[0]), 128'(1));
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 64'h55; wr_be = '1;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
        tick(); idle();
        chk("pend_clear_bypass", 128'(rd_pend[0]), 128'(0));
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 64'h99; wr_be = '1;
        pend_set = 1'b1; pend_addr = 4'd9;
        tick(); idle();
        rd_en = 2'b10; rd_addr = {4'd9, 4'd0};
        tick(); idle();
        chk("pend_set_wins", 128'(rd_pend[1]), 128'(1));

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            wr_en     = ($urandom % 2) == 0;
            wr_addr   = AW'($urandom % DEP);
            wr_data   = {$urandom, $urandom};
            wr_be     = 8'($urandom);
            pend_set  = ($urandom % 3) == 0;
            pend_addr = AW'($urandom % DEP);
            rd_en     = 2'($urandom);
            rd_addr   = {AW'($urandom % DEP), AW'($urandom % DEP)};
            if (($urandom % 4) == 0) rd_addr[AW-1:0] = wr_addr;
            init_req  = ($urandom % 150) == 0;
            tick();
            if (busy) begin
                idle();
                while (busy) tick();
            end
        end
        idle();
        tick();

        // Fill, then init_req sweep with ignored traffic.
        for (int i = 0; i < DEP; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = {$urandom | 32'h1, $urandom}; wr_be = '1;
            pend_set = 1'b1; pend_addr = AW'(DEP - 1 - i);
            tick();
        end
        idle();
        init_req = 1'b1;
        tick(); idle();
        begin
            int n;
            n = 0;
            while (busy && n < 100) begin
                wr_en = 1'b1; wr_addr = AW'($urandom % DEP); wr_data = '1; wr_be = '1;
                rd_en = 2'b11; rd_addr = {AW'($urandom % DEP), AW'($urandom % DEP)};
                n++;
                tick();
                if (busy) chk("sweep_rd_valid", 128'(rd_valid), 128'(0));
            end
            chk("busy_len_init_req", 128'(n), 128'(DEP));
        end
        idle();
        for (int i = 0; i < DEP; i++) begin
            rd_en = 2'b11; rd_addr = {AW'(i), AW'(i)};
            tick();
            chk("swept_data", 128'(rd_data), 128'(0));
            chk("swept_pend", 128'(rd_pend), 128'(0));
        end
        idle();

        // Reset in the middle of a sweep.
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 64'hDEADBEEF; wr_be = '1;
        tick(); idle();
        rd_en = 2'b01; rd_addr = {4'd0, 4'd2}; init_req = 1'b1;
        tick(); idle();
        chk("pre_reset_data", 128'(rd_data[DW-1:0]), 128'(64'hDEADBEEF));
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", 128'(rd_data), 128'(0));
        chk("async_rst_valid", 128'(rd_valid), 128'(0));
        chk("async_rst_busy", 128'(busy), 128'(1));
        tick(); tick();
        rst_n = 1'b1;
        count_busy("busy_len_rerelease");
        rd_en = 2'b11; rd_addr = {4'd2, 4'd2};
        tick(); idle();
        chk("rerelease_data", 128'(rd_data), 128'(0));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, multi-read-port successor to the CGRA PE register file.
- One byte-enabled write port and NRD registered read ports, with write-to-read bypass.
- Per-entry pending scoreboard, so producers can reserve a destination and consumers can detect stale data.
- A hardware init sequencer zeroes the array after reset or on request, so no simulation-only initialisation is needed.
- Sits inside each CGRA PE between the phit datapath and the ALU operand muxes.

Parameters:
- DWIDTH, default 512 (phit_size): entry width in bits; must be a multiple of 8.
- DEPTH, default 16: number of entries; any value ≥ 2.
- NRD, default 2: number of independent read ports.
- AWIDTH, default $clog2(DEPTH): address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- init_req  in  1  pulse; starts a zeroing sweep (ignored while busy).
- busy  out  1  high while the init sweep runs.
- wr_en  in  1  write strobe.
- wr_addr  in  AWIDTH  write address.
- wr_data  in  DWIDTH  write data.
- wr_be  in  DWIDTH/8  byte enables; bit b covers data[8b+7:8b].
- pend_set  in  1  mark pend_addr as pending.
- pend_addr  in  AWIDTH  entry to mark.
- rd_en  in  NRD  per-port read strobe.
- rd_addr  in  NRD*AWIDTH  port k uses slice [k*AWIDTH +: AWIDTH].
- rd_data  out  NRD*DWIDTH  registered read data, port k at slice [k*DWIDTH +: DWIDTH].
- rd_valid  out  NRD  rd_data slice k is valid this cycle.
- rd_pend  out  NRD  pending bit of the entry read by port k.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data=0, rd_valid=0, rd_pend=0, all pend bits=0.
  - FSM goes to INIT with the sweep counter at 0; busy=1.
  - Array contents are not reset directly; the sweep zeroes them.
- FSM states: INIT, RUN.
  - INIT: each cycle writes 0 to entry cnt and clears pend[cnt], then cnt++.
  - On the cycle cnt==DEPTH-1 is written, the next state is RUN. busy is therefore high for exactly DEPTH cycles after reset release.
  - RUN: init_req=1 sends the FSM to INIT with cnt=0; busy rises the next cycle.
  - Deasserting rst_n during INIT restarts the sweep from 0.
- During INIT: wr_en, pend_set and rd_en are ignored; rd_valid=0.
- Write (RUN, wr_en=1): for each byte b with wr_be[b]=1, mem[wr_addr] byte b is updated at posedge. Bytes with wr_be=0 are unchanged. wr_be=0 writes nothing but still clears pend.
- Reads: rd_en[k] at cycle N gives rd_valid[k]=1 and rd_data slice k at cycle N+1 (latency 1).
  - With rd_en[k]=0, rd_valid[k]=0 and rd_data slice k holds its last value.
- Bypass: if wr_en is high and wr_addr==rd_addr[k] in the same cycle, port k returns the byte-merged result (enabled bytes from wr_data, others from the old entry). Read-after-write is never stale.
- Several ports may read the same address, or the write address, in the same cycle.
- Pending scoreboard:
  - pend_set sets pend[pend_addr].
  - A write (wr_en=1) clears pend[wr_addr].
  - Same-cycle set and write to the same address: set wins; the bit ends at 1.
- rd_pend[k] (valid with rd_valid[k]) is pend[rd_addr] after this cycle's write-clear, before this cycle's set. It matches the bypassed data.
- Out-of-range addresses (DEPTH not a power of 2): writes are dropped, reads return 0 with rd_pend=0.

Test Plan:
- Reset release, DEPTH=16: busy is high for exactly 16 cycles. Then rd_en=2'b11 on addresses 0 and 15 gives rd_data=0 on both ports and rd_valid=11 one cycle later.
- Write addr 3 with data 0xA5 repeated and wr_be all-ones. Then write addr 3 with wr_data=0, wr_be=1 (byte 0 only). A read of addr 3 returns 0xA5A5…A500.
- Same cycle: wr_en to addr 7 with 0x1234 (full be), and ports 0 and 1 both read addr 7. Next cycle both ports show 0x1234 with rd_valid=11.
- pend_set on addr 5, then read addr 5 gives rd_pend=1. Write addr 5 while port 0 reads addr 5 in the same cycle gives rd_pend=0. pend_set and wr_en on addr 9 in the same cycle, then a later read of 9 gives rd_pend=1.
- In RUN, fill entries with nonzero data and pulse init_req. busy is high for 16 cycles, and rd_en/wr_en issued during the sweep are ignored (rd_valid=0). After the sweep all entries read 0 with rd_pend=0.
- Deassert rst_n at INIT cycle 6: outputs go to 0 immediately. After release, busy stays high for a full 16 cycles.
